// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and IMEM write-port bundle for the boot loader.
// The slave side is the loader. The master side is whatever feeds the stream
// and observes the IMEM write port.
interface imem_boot_loader_if #(
    parameter int XLEN        = 32,
    parameter int IMEM_ADDR_W = 10
);
    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   imem_we;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]        imem_wdata;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: turns a framed byte stream (LEN | words | CSUM) into IMEM writes.
// The core stays in reset until the whole image has loaded and its checksum matches.
module imem_boot_loader #(
    parameter int XLEN        = 32,
    parameter int IMEM_ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,        // asynchronous, active-low
    input  logic                restart,    // synchronous reload request
    imem_boot_loader_if.slave   bus,
    output logic                core_rst,   // active-low core reset, 1 = running
    output logic                boot_done,
    output logic                boot_err
);
    // The word counter is one bit wider than the address so that a full-capacity
    // image (N == 2**IMEM_ADDR_W) can be counted without wrapping.
    localparam int          CW  = IMEM_ADDR_W + 1;
    localparam logic [32:0] CAP = 33'(1) << IMEM_ADDR_W;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                 state_q,    state_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]          word_cnt_q, word_cnt_d;
    logic [CW-1:0]          len_q,      len_d;
    logic [7:0]             sum_q,      sum_d;
    logic [23:0]            asm_q,      asm_d;
    logic                   we_q,       we_d;
    logic [IMEM_ADDR_W-1:0] addr_q,     addr_d;
    logic [XLEN-1:0]        wdata_q,    wdata_d;

    logic                   accept;
    logic [31:0]            word_full;
    logic [32:0]            len_full;

    // Readiness depends on the state register alone, never on in_valid.
    assign bus.in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept       = bus.in_valid && bus.in_ready;

    // The incoming byte is always lane 3 of the word being completed.
    assign word_full    = {bus.in_data, asm_q};
    assign len_full     = {1'b0, word_full};

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    assign core_rst  = (state_q == S_RUN);
    assign boot_done = (state_q == S_RUN);
    assign boot_err  = (state_q == S_ERR);

    // Next-state logic: byte assembly, length check, IMEM write generation, checksum.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        sum_d      = sum_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (restart) begin
            // A byte offered in the same cycle is dropped.
            state_d    = S_LEN;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            len_d      = '0;
            sum_d      = '0;
            asm_d      = '0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    asm_d[7:0]   = bus.in_data;
                2'd1:    asm_d[15:8]  = bus.in_data;
                2'd2:    asm_d[23:16] = bus.in_data;
                default: ;
            endcase

            case (state_q)
                S_LEN: begin
                    if (byte_cnt_q == 2'd3) begin
                        len_d = word_full[CW-1:0];
                        if (word_full == 32'd0) begin
                            state_d = S_CSUM;
                        end else if (len_full > CAP) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    sum_d = sum_q + bus.in_data;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[IMEM_ADDR_W-1:0];
                        wdata_d    = word_full;
                        word_cnt_d = word_cnt_q + CW'(1);
                        if (word_cnt_d == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    state_d = (bus.in_data == sum_q) ? S_RUN : S_ERR;
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LEN;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed and randomized frames checked against a
// frame-level reference model.
module tb_imem_boot_loader;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    logic restart;
    logic core_rst, boot_done, boot_err;

    imem_boot_loader_if #(.XLEN(32), .IMEM_ADDR_W(AW)) bus ();

    imem_boot_loader #(.XLEN(32), .IMEM_ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .bus       (bus),
        .core_rst  (core_rst),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int we_count    = 0;
    bit rand_idle   = 1'b0;

    byte unsigned frame_q[$];
    logic [31:0]  exp_word[$];
    int           exp_n_acc;
    bit           exp_ok;
    bit           exp_err;

    // Count every IMEM write strobe seen outside reset.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.imem_we === 1'b1) we_count++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push32(input logic [31:0] w);
        frame_q.push_back(w[7:0]);
        frame_q.push_back(w[15:8]);
        frame_q.push_back(w[23:16]);
        frame_q.push_back(w[31:24]);
    endtask

    // Reference model: parse the whole frame by the protocol rules.
    task automatic model();
        logic [31:0] n;
        logic [31:0] w;
        logic [7:0]  s;
        n = {frame_q[3], frame_q[2], frame_q[1], frame_q[0]};
        exp_word.delete();
        if (n > 32'(1 << AW)) begin
            exp_n_acc = 4;
            exp_ok    = 1'b0;
            exp_err   = 1'b1;
        end else begin
            s = 8'd0;
            for (int i = 0; i < int'(n); i++) begin
                w = {frame_q[4+4*i+3], frame_q[4+4*i+2], frame_q[4+4*i+1], frame_q[4+4*i]};
                exp_word.push_back(w);
                s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
            end
            exp_n_acc = 4 + 4 * int'(n) + 1;
            exp_ok    = (frame_q[exp_n_acc-1] == s);
            exp_err   = !exp_ok;
        end
    endtask

    // Offer one byte; returns at 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        if (rand_idle) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                chk("core_rst_held", core_rst, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $error("FAIL handshake_timeout: observed no in_ready expected in_ready");
        end
    endtask

    task automatic run_frame(input string tag);
        int  base;
        int  wi;
        bit  ok;
        model();
        base = we_count;
        wi   = 0;
        for (int j = 0; j < exp_n_acc; j++) begin
            send_byte(frame_q[j], ok);
            if (!ok) return;
            if (j >= 4 && j <= exp_n_acc - 2 && (j % 4) == 3) begin
                chk({tag, "_we"},    bus.imem_we,    1'b1);
                chk({tag, "_addr"},  bus.imem_addr,  wi);
                chk({tag, "_wdata"}, bus.imem_wdata, exp_word[wi]);
                wi++;
            end else begin
                chk({tag, "_we_idle"}, bus.imem_we, 1'b0);
            end
        end
        chk({tag, "_core_rst"},  core_rst,  exp_ok);
        chk({tag, "_boot_done"}, boot_done, exp_ok);
        chk({tag, "_boot_err"},  boot_err,  exp_err);
        chk({tag, "_in_ready"},  bus.in_ready, 1'b0);
        chk({tag, "_nwrites"},   we_count - base, exp_word.size());
        // Extra bytes after the frame must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, "_extra_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_extra_core"},  core_rst, exp_ok);
        chk({tag, "_extra_nwr"},   we_count - base, exp_word.size());
    endtask

    task automatic do_restart();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        restart      = 1'b1;
        @(posedge clk);
        #1;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        chk("rs_in_ready",  bus.in_ready, 1'b1);
        chk("rs_core_rst",  core_rst,     1'b0);
        chk("rs_boot_done", boot_done,    1'b0);
        chk("rs_boot_err",  boot_err,     1'b0);
        chk("rs_we",        bus.imem_we,  1'b0);
    endtask

    task automatic build_prog();
        frame_q.delete();
        push32(32'd2);
        push32(32'h00500093);
        push32(32'h00100113);
        frame_q.push_back(8'h07);
    endtask

    initial begin
        bit          ok;
        logic [31:0] w;
        logic [7:0]  s;
        int          n;

        rst          = 1'b0;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #20;
        chk("rst_in_ready",  bus.in_ready,   1'b1);
        chk("rst_core_rst",  core_rst,       1'b0);
        chk("rst_boot_done", boot_done,      1'b0);
        chk("rst_boot_err",  boot_err,       1'b0);
        chk("rst_we",        bus.imem_we,    1'b0);
        chk("rst_addr",      bus.imem_addr,  0);
        chk("rst_wdata",     bus.imem_wdata, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Two-word program with a correct checksum.
        build_prog();
        run_frame("t1");

        // Same program with a bad checksum.
        do_restart();
        frame_q[frame_q.size()-1] = 8'hA6;
        run_frame("t2");

        // Length one past capacity.
        do_restart();
        frame_q.delete();
        push32(32'h00000401);
        push32(32'h11223344);
        frame_q.push_back(8'haa);
        run_frame("t3");

        // Random in_valid gaps, single word.
        do_restart();
        rand_idle = 1'b1;
        frame_q.delete();
        push32(32'd1);
        push32(32'hDEADBEEF);
        frame_q.push_back(8'h38);
        run_frame("t4");
        rand_idle = 1'b0;

        // Restart after five data bytes, then a clean load.
        do_restart();
        build_prog();
        for (int j = 0; j < 9; j++) send_byte(frame_q[j], ok);
        do_restart();
        run_frame("t5");

        // Asynchronous reset in the middle of the data phase.
        do_restart();
        build_prog();
        for (int j = 0; j < 10; j++) send_byte(frame_q[j], ok);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_in_ready",  bus.in_ready,   1'b1);
        chk("ar_core_rst",  core_rst,       1'b0);
        chk("ar_boot_done", boot_done,      1'b0);
        chk("ar_boot_err",  boot_err,       1'b0);
        chk("ar_we",        bus.imem_we,    1'b0);
        chk("ar_addr",      bus.imem_addr,  0);
        chk("ar_wdata",     bus.imem_wdata, 0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_frame("t6");

        // Empty image: checksum byte must be zero.
        do_restart();
        frame_q.delete();
        push32(32'd0);
        frame_q.push_back(8'h00);
        run_frame("t7");

        // Randomized frames with random gaps and occasional bad checksums.
        rand_idle = 1'b1;
        for (int k = 0; k < 6; k++) begin
            do_restart();
            frame_q.delete();
            n = $urandom_range(1, 6);
            push32(32'(n));
            s = 8'd0;
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                push32(w);
                s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
            end
            if ($urandom_range(0, 2) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
            frame_q.push_back(s);
            run_frame("rnd");
        end
        rand_idle = 1'b0;

        // Huge random length.
        do_restart();
        frame_q.delete();
        push32(32'h8000_0000 | 32'($urandom));
        run_frame("big");

        // Full-capacity image, back-to-back bytes.
        do_restart();
        frame_q.delete();
        push32(32'(1 << AW));
        s = 8'd0;
        for (int i = 0; i < (1 << AW); i++) begin
            w = $urandom;
            push32(w);
            s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
        end
        frame_q.push_back(s);
        run_frame("full");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
